// File: rtl/multiplier_4_bit_pkg.sv
// Shared definitions for the shift-and-add multiplier: operand width,
// controller state encoding and a counter-width helper.
package multiplier_4_bit_pkg;

    // Default operand width; the product is twice this wide.
    localparam int WIDTH = 4;

    // Controller states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Bits needed to count iterations 0 .. w-1 (at least one bit).
    function automatic int cnt_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/mult_shift_add_dp.sv
// Shift-and-add datapath: operand registers, accumulator, iteration
// counter and the conditional adder. Sequenced by the controller through
// load_i (capture operands, clear accumulator/counter) and step_i (one
// partial-product iteration).
module mult_shift_add_dp
    import multiplier_4_bit_pkg::*;
#(
    parameter int WIDTH = multiplier_4_bit_pkg::WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load_i,
    input  logic                 step_i,
    input  logic [WIDTH-1:0]     a_i,
    input  logic [WIDTH-1:0]     b_i,
    output logic [2*WIDTH-1:0]   acc_next_o,
    output logic                 last_o
);

    localparam int CNT_W = cnt_width(WIDTH);

    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic [2*WIDTH-1:0] a_ext;
    logic [2*WIDTH-1:0] addend;
    logic [2*WIDTH-1:0] sum;
    logic               last;

    // Partial product for the current iteration and the next-state of every register.
    always_comb begin
        a_ext  = {{WIDTH{1'b0}}, a_q};
        addend = b_q[cnt_q] ? (a_ext << cnt_q) : '0;
        sum    = acc_q + addend;
        last   = (cnt_q == CNT_W'(WIDTH - 1));

        a_d   = a_q;
        b_d   = b_q;
        acc_d = acc_q;
        cnt_d = cnt_q;

        if (load_i) begin
            a_d   = a_i;
            b_d   = b_i;
            acc_d = '0;
            cnt_d = '0;
        end else if (step_i) begin
            acc_d = sum;
            cnt_d = last ? '0 : cnt_q + CNT_W'(1);
        end
    end

    assign acc_next_o = sum;
    assign last_o     = last;

    // Datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q   <= '0;
            b_q   <= '0;
            acc_q <= '0;
            cnt_q <= '0;
        end else begin
            a_q   <= a_d;
            b_q   <= b_d;
            acc_q <= acc_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/multiplier_4_bit.sv
// Sequential unsigned multiplier: IDLE/RUN/DONE controller, output
// registers and the shift-and-add datapath instance.
//
// Handshake: start is sampled only in IDLE; an accepted start captures a
// and b on that edge and raises busy from the next cycle. busy stays high
// through RUN (WIDTH cycles) and DONE (one cycle). done is a single-cycle
// pulse during DONE, in which product first shows the new result. start
// seen while busy is dropped, not queued. product holds until the next
// completion and is cleared by reset.
module multiplier_4_bit
    import multiplier_4_bit_pkg::*;
#(
    parameter int WIDTH = multiplier_4_bit_pkg::WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product,
    output state_t               dbg_state
);

    state_t             state_q, state_d;
    logic               busy_q, done_q;
    logic [2*WIDTH-1:0] product_q, product_d;

    logic               dp_load;
    logic               dp_step;
    logic [2*WIDTH-1:0] acc_next;
    logic               dp_last;

    mult_shift_add_dp #(
        .WIDTH (WIDTH)
    ) u_dp (
        .clk        (clk),
        .rst        (rst),
        .load_i     (dp_load),
        .step_i     (dp_step),
        .a_i        (a),
        .b_i        (b),
        .acc_next_o (acc_next),
        .last_o     (dp_last)
    );

    // Next-state, datapath control and product update.
    always_comb begin
        state_d   = state_q;
        dp_load   = 1'b0;
        dp_step   = 1'b0;
        product_d = product_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    dp_load = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                dp_step = 1'b1;
                if (dp_last) begin
                    product_d = acc_next;
                    state_d   = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; busy/done are registered from the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            busy_q    <= (state_d != IDLE);
            done_q    <= (state_d == DONE);
            product_q <= product_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign product   = product_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_multiplier_4_bit.sv
// Directed and randomized checks for multiplier_4_bit against a plain
// arithmetic reference (a*b, fixed 6-cycle operation timing).
module tb_multiplier_4_bit;
    import multiplier_4_bit_pkg::*;

    // ---------------- clock / reset ----------------
    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [3:0] a;
    logic [3:0] b;
    logic       busy;
    logic       done;
    logic [7:0] product;
    state_t     dbg_state;

    always #5 clk = ~clk;

    multiplier_4_bit #(
        .WIDTH (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .done      (done),
        .product   (product),
        .dbg_state (dbg_state)
    );

    // ---------------- scoreboard ----------------
    int         checks = 0;
    int         errors = 0;
    logic [7:0] prev_product;   // last completed result per the reference

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // ---------------- driver ----------------
    // Called just after a falling edge with the DUT idle; returns after the
    // falling edge that follows the return to IDLE.
    task automatic run_op(input logic [3:0] av, input logic [3:0] bv, input bit poke);
        logic [7:0] exp_p;
        exp_p = 8'(int'(av) * int'(bv));
        start = 1'b1;
        a     = av;
        b     = bv;
        @(negedge clk);                       // E0 has captured the operands
        start = 1'b0;
        a     = 4'($urandom_range(0, 15));    // later operand changes must not matter
        b     = 4'($urandom_range(0, 15));
        check("busy_e0", 8'(busy), 8'd1);
        check("done_e0", 8'(done), 8'd0);
        check("hold_e0", product, prev_product);
        for (int k = 1; k <= 3; k++) begin
            if (poke && k == 1) begin
                start = 1'b1;
                a     = 4'd9;
                b     = 4'd9;
            end
            @(negedge clk);
            start = 1'b0;
            a     = 4'($urandom_range(0, 15));
            b     = 4'($urandom_range(0, 15));
            check("done_run", 8'(done), 8'd0);
            check("busy_run", 8'(busy), 8'd1);
            check("hold_run", product, prev_product);
        end
        @(negedge clk);                       // after E4: result visible
        check("done_pulse", 8'(done), 8'd1);
        check("busy_done", 8'(busy), 8'd1);
        check("product", product, exp_p);
        prev_product = exp_p;
        @(negedge clk);                       // after E5: back in IDLE
        check("done_after", 8'(done), 8'd0);
        check("busy_after", 8'(busy), 8'd0);
        check("product_kept", product, exp_p);
    endtask

    logic [3:0] sweep_a [10] = '{4'd6, 4'd2, 4'd7, 4'd7, 4'd5, 4'd7, 4'd4, 4'd0,  4'd15, 4'd1};
    logic [3:0] sweep_b [10] = '{4'd6, 4'd6, 4'd5, 4'd7, 4'd5, 4'd3, 4'd6, 4'd9,  4'd15, 4'd13};

    // ---------------- stimulus ----------------
    initial begin
        rst          = 1'b1;
        start        = 1'b1;   // reset must win over start
        a            = 4'd3;
        b            = 4'd3;
        prev_product = 8'd0;
        repeat (2) @(negedge clk);
        check("rst_busy", 8'(busy), 8'd0);
        check("rst_done", 8'(done), 8'd0);
        check("rst_product", product, 8'd0);
        assert (dbg_state === IDLE) else begin
            errors++;
            $error("FAIL rst_state observed=%0d expected=%0d", dbg_state, IDLE);
        end
        checks++;
        rst   = 1'b0;
        start = 1'b0;
        @(negedge clk);

        // directed sweep and boundary operands
        for (int i = 0; i < 10; i++) run_op(sweep_a[i], sweep_b[i], 1'b0);

        // second start during RUN is ignored
        run_op(4'd3, 4'd4, 1'b1);

        // randomized operands
        for (int i = 0; i < 25; i++)
            run_op(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1'b0);

        // reset in the middle of an operation
        run_op(4'd5, 4'd5, 1'b0);
        start = 1'b1;
        a     = 4'd2;
        b     = 4'd3;
        @(negedge clk);                       // E0
        start = 1'b0;
        @(negedge clk);                       // E1
        rst = 1'b1;
        @(negedge clk);                       // E2 with reset
        rst = 1'b0;
        prev_product = 8'd0;
        check("abort_product", product, 8'd0);
        check("abort_busy", 8'(busy), 8'd0);
        check("abort_done", 8'(done), 8'd0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("abort_no_done", 8'(done), 8'd0);
        end
        run_op(4'd2, 4'd3, 1'b0);

        // start held high: a new operation every 6 cycles
        start = 1'b1;
        a     = 4'd3;
        b     = 4'd5;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            check("held_done", 8'(done), (n % 6 == 4) ? 8'd1 : 8'd0);
            if (n % 6 == 4) check("held_product", product, 8'd15);
        end
        start = 1'b0;
        for (int c = 0; c < 12 && busy; c++) @(negedge clk);
        check("drain_busy", 8'(busy), 8'd0);
        check("drain_product", product, 8'd15);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/multiplier_4_bit.md
MULTIPLIER_4_BIT -- requirements
Module: multiplier_4_bit

Interface
REQ-001 Parameter: WIDTH, default 4, operand width; the product is 2*WIDTH bits. All values below assume WIDTH=4.
REQ-002 The block SHALL use one clock and a synchronous, active-high reset.
REQ-003 Port clk, input, 1 bit: sole clock; all state changes on the rising edge.
REQ-004 Port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 Port start, input, 1 bit: request a multiply of a and b.
REQ-006 Port a, input, 4 bits: unsigned multiplicand.
REQ-007 Port b, input, 4 bits: unsigned multiplier.
REQ-008 Port busy, output, 1 bit: a multiply is in progress.
REQ-009 Port done, output, 1 bit: one-cycle pulse marking a new valid product.
REQ-010 Port product, output, 8 bits: unsigned a*b of the last completed operation.

Function
REQ-011 FSM states SHALL be IDLE, RUN, DONE.
REQ-012 IDLE -> RUN: on an edge where start=1 in IDLE; that edge SHALL capture a and b into internal registers, clear the accumulator and load the iteration counter with 0.
REQ-013 In RUN, each edge SHALL add (captured a << i) to the accumulator when captured bit b[i]=1, where i is the counter value, then increment i.
REQ-014 RUN -> DONE: on the edge processing i=3, so RUN lasts exactly 4 cycles.
REQ-015 That same edge SHALL load product with the final accumulator value.
REQ-016 DONE -> IDLE: unconditionally after one cycle.
REQ-017 done=1 exactly during the DONE cycle.
REQ-018 busy=1 during RUN and DONE; busy=0 in IDLE.
REQ-019 Latency: if start is sampled on edge E0, product is updated and done is high in the cycle after edge E4.
REQ-020 Product SHALL hold its previous value during RUN and until the next completion.
REQ-021 Arithmetic SHALL be unsigned with an 8-bit accumulator; no overflow is possible (max 15*15=225).
REQ-022 start SHALL be ignored in RUN and DONE; no queuing.
REQ-023 Changes on a and b after capture SHALL NOT affect the operation in progress.
REQ-024 start held high continuously SHALL launch a new operation on each IDLE edge, i.e. once every 6 cycles.

Reset
REQ-025 With rst=1 at an edge: state=IDLE, busy=0, done=0, product=0, accumulator=0, counter=0.
REQ-026 Reset SHALL take precedence over start.
REQ-027 Reset mid-operation SHALL abort the operation with no done pulse; product reads 0.

Structure
REQ-028 Package multiplier_4_bit_pkg SHALL hold WIDTH and the state enum type (IDLE/RUN/DONE).
REQ-029 One sub-module, mult_shift_add_dp, SHALL hold the operand registers, accumulator, counter and conditional adder.
REQ-030 The top level SHALL hold the FSM and the output registers.

Verification
REQ-031 Sweep a=6,b=6 -> 36 (00100100); 2,6 -> 12; 7,5 -> 35; 7,7 -> 49; 5,5 -> 25; 7,3 -> 21; 4,6 -> 24. Each result SHALL appear with a single done pulse exactly 5 edges after start.
REQ-032 Boundaries: 0*9 -> 0; 15*15 -> 225 (11100001); 1*13 -> 13; done SHALL still pulse for a zero result.
REQ-033 Pulse start with 3*4, then pulse start again with 9*9 during RUN -> second start ignored; product=12; exactly one done pulse.
REQ-034 Change a and b during RUN -> result reflects the captured operands only.
REQ-035 Let 5*5 complete (product=25), start 2*3, assert rst for one edge at E2 -> product=0, busy=0, no done pulse; then 2*3 -> 6.
REQ-036 Hold start high for 20 cycles with a=3, b=5 -> done pulses every 6 cycles; product=15 each time.
